// File: rtl/latch_d_writer_pkg.sv
// latch_d_writer_pkg: state encoding and default phase lengths shared by latch-bank controllers.
package latch_d_writer_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } state_t;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_HOLD_CYC  = 1;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/latch_d_writer_if.sv
// latch_d_writer_if: valid/ready write port carrying one word per transfer.
interface latch_d_writer_if #(parameter int WIDTH = 8);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    modport master(output valid, data, input ready);
    modport slave(input valid, data, output ready);
endinterface

// File: rtl/latch_d_writer.sv
// latch_d_writer: sequences setup / enable pulse / hold for a D-latch bank and reads it back.
module latch_d_writer
    import latch_d_writer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic             CLK,
    input  logic             RST,
    latch_d_writer_if.slave  wr,
    output logic [WIDTH-1:0] lat_D,
    output logic             lat_EN,
    input  logic [WIDTH-1:0] lat_Q,
    output logic             done,
    output logic             mismatch
);
    localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
        $error("latch_d_writer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end
    state_t        state, nxt;
    logic [CW-1:0] cnt, load;
    logic          xfer, last;
    assign wr.ready = state == IDLE || state == CHECK;
    assign xfer     = wr.valid && wr.ready;
    assign last     = cnt == '0;
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = xfer ? SETUP : IDLE;
            SETUP:   nxt = last ? PULSE : SETUP;
            PULSE:   nxt = last ? HOLD : PULSE;
            HOLD:    nxt = last ? CHECK : HOLD;
            CHECK:   nxt = xfer ? SETUP : IDLE;
            default: nxt = IDLE;
        endcase
        load = nxt == SETUP ? CW'(SETUP_CYC - 1) :
               nxt == PULSE ? CW'(PULSE_CYC - 1) :
               nxt == HOLD  ? CW'(HOLD_CYC - 1)  : '0;
    end
    // Outputs come from nxt so lat_EN is a clean flop output aligned with the state;
    // lat_Q is sampled on the edge leaving the last HOLD cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_D    <= '0;
            lat_EN   <= 1'b0;
            done     <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= nxt != state ? load : (last ? cnt : cnt - 1'b1);
            lat_D    <= xfer ? wr.data : lat_D;
            lat_EN   <= nxt == PULSE;
            done     <= nxt == CHECK;
            mismatch <= nxt == CHECK && lat_Q != lat_D;
        end
    end
endmodule
